// File: rtl/scanner_buffer_unit_pkg.sv
// Shared definitions for the scanner buffer unit: default sizes and the FSM state encoding.
package scanner_buffer_unit_pkg;

  localparam int DATA_W_DEF      = 8;
  localparam int DEPTH_DEF       = 8;
  localparam int READY_LEVEL_DEF = 6;
  localparam int LP_TIMEOUT_DEF  = 50;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SCANNING  = 3'd1,
    ST_READY     = 3'd2,
    ST_TRANSFER  = 3'd3,
    ST_LOW_POWER = 3'd4
  } state_t;

endpackage

// File: rtl/scanner_buffer_unit_strobe_edge.sv
// Rising-edge detector for a PIO strobe level.
// History resets high, so a strobe that is already high when reset releases does not fire.
module strobe_edge (
  input  logic clk,
  input  logic rst,
  input  logic strobe,
  output logic pulse
);

  logic prev;

  // Remember last cycle's strobe level so a 0->1 transition can be spotted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) prev <= 1'b1;
    else      prev <= strobe;
  end

  assign pulse = strobe & ~prev;

endmodule

// File: rtl/scanner_buffer_unit.sv
// Scan-data buffer: CPU pushes samples into a small FIFO, the block flags READY at a fill
// level, then the CPU drains it one byte per read strobe before the block drops to low power.
module scanner_buffer_unit
  import scanner_buffer_unit_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int DEPTH       = DEPTH_DEF,
  parameter int READY_LEVEL = READY_LEVEL_DEF,
  parameter int LP_TIMEOUT  = LP_TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_scan,
  input  logic              transfer_input,
  input  logic              wr_en,
  input  logic              read_inc,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic [DATA_W-1:0] data_out_cpu,
  output logic              ready_to_transfer,
  output logic              overflow,
  output logic [2:0]        state
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int LP_W  = $clog2(LP_TIMEOUT);

  localparam logic [CNT_W-1:0] FULL_CNT     = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] PRE_READY    = CNT_W'(READY_LEVEL - 1);
  localparam logic [CNT_W-1:0] ONE_CNT      = CNT_W'(1);
  localparam logic [LP_W-1:0]  LP_LAST      = LP_W'(LP_TIMEOUT - 1);

  logic              scan_pulse, xfer_pulse, wr_pulse, rd_pulse;
  state_t            cur_state, next_state;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr, rd_ptr_next;
  logic [CNT_W-1:0]  count, count_next;
  logic [LP_W-1:0]   lp_cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] head_next;
  logic              do_push, do_pop, drop;

  strobe_edge u_scan_edge (.clk(clk), .rst(rst), .strobe(start_scan),     .pulse(scan_pulse));
  strobe_edge u_xfer_edge (.clk(clk), .rst(rst), .strobe(transfer_input), .pulse(xfer_pulse));
  strobe_edge u_wr_edge   (.clk(clk), .rst(rst), .strobe(wr_en),          .pulse(wr_pulse));
  strobe_edge u_rd_edge   (.clk(clk), .rst(rst), .strobe(read_inc),       .pulse(rd_pulse));

  // Decide what this edge does: push, pop, drop, and where the FSM goes next.
  always_comb begin
    do_push    = 1'b0;
    do_pop     = 1'b0;
    drop       = 1'b0;
    next_state = cur_state;
    case (cur_state)
      ST_IDLE: begin
        if (scan_pulse) next_state = ST_SCANNING;
      end
      ST_SCANNING: begin
        if (wr_pulse && count != FULL_CNT) begin
          do_push = 1'b1;
          if (count >= PRE_READY) next_state = ST_READY;
        end
      end
      ST_READY: begin
        if (wr_pulse) begin
          if (count == FULL_CNT) drop = 1'b1;
          else                   do_push = 1'b1;
        end
        if (xfer_pulse) next_state = ST_TRANSFER;
      end
      ST_TRANSFER: begin
        if (rd_pulse) begin
          do_pop = 1'b1;
          if (count == ONE_CNT) next_state = ST_LOW_POWER;
        end
      end
      ST_LOW_POWER: begin
        if (scan_pulse)            next_state = ST_SCANNING;
        else if (lp_cnt == LP_LAST) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Post-update occupancy and head byte; a push into an empty FIFO becomes the head directly.
  always_comb begin
    count_next  = count;
    rd_ptr_next = rd_ptr;
    if (do_push) count_next = count + ONE_CNT;
    if (do_pop) begin
      count_next  = count - ONE_CNT;
      rd_ptr_next = rd_ptr + PTR_W'(1);
    end
    if (count_next == '0)               head_next = '0;
    else if (do_push && count == '0)    head_next = data_in;
    else                                head_next = mem[rd_ptr_next];
  end

  // FIFO storage; contents survive reset and are masked by a zero count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= data_in;
  end

  // FSM state, FIFO bookkeeping and all registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_state         <= ST_IDLE;
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      count             <= '0;
      lp_cnt            <= '0;
      data_out          <= '0;
      data_out_cpu      <= '0;
      ready_to_transfer <= 1'b0;
      overflow          <= 1'b0;
    end else begin
      cur_state         <= next_state;
      count             <= count_next;
      rd_ptr            <= rd_ptr_next;
      data_out_cpu      <= head_next;
      ready_to_transfer <= (next_state == ST_READY);
      if (do_push) begin
        wr_ptr   <= wr_ptr + PTR_W'(1);
        data_out <= data_in;
      end
      if (drop) overflow <= 1'b1;
      if (cur_state == ST_LOW_POWER && next_state == ST_LOW_POWER) lp_cnt <= lp_cnt + LP_W'(1);
      else                                                         lp_cnt <= '0;
    end
  end

  assign state = cur_state;

endmodule
